// File: rtl/cache_sram_loader_if.sv
// Element-stream and SRAM-write bundle for cache_sram_loader.
// The master drives the load command and element stream; the slave (the loader) drives the SRAM side.
interface cache_sram_loader_if #(
    parameter int ELEMENT_WIDTH      = 32,
    parameter int ELEMENTS_PER_BLOCK = 4,
    parameter int LG_DEPTH           = 6
);
    localparam int BW = ELEMENT_WIDTH * ELEMENTS_PER_BLOCK;

    logic                     io_start;
    logic [LG_DEPTH-1:0]      io_base_addr;
    logic [LG_DEPTH:0]        io_num_blocks;
    logic                     io_abort;
    logic                     io_elem_valid;
    logic [ELEMENT_WIDTH-1:0] io_elem_data;
    logic                     io_elem_ready;
    logic [LG_DEPTH-1:0]      io_sram_addr;
    logic [BW-1:0]            io_sram_din;
    logic                     io_sram_we;
    logic                     io_busy;
    logic                     io_done;

    modport master (
        output io_start, io_base_addr, io_num_blocks, io_abort,
        output io_elem_valid, io_elem_data,
        input  io_elem_ready, io_sram_addr, io_sram_din, io_sram_we,
        input  io_busy, io_done
    );

    modport slave (
        input  io_start, io_base_addr, io_num_blocks, io_abort,
        input  io_elem_valid, io_elem_data,
        output io_elem_ready, io_sram_addr, io_sram_din, io_sram_we,
        output io_busy, io_done
    );
endinterface

// File: rtl/cache_sram_loader.sv
// Packs a stream of elements into SRAM-word blocks and writes them to consecutive
// (wrapping) addresses, one write cycle per block, with abort and completion pulse.
module cache_sram_loader #(
    parameter int ELEMENT_WIDTH      = 32,
    parameter int ELEMENTS_PER_BLOCK = 4,
    parameter int DEPTH              = 64,
    parameter int LG_DEPTH           = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cache_sram_loader_if.slave   bus
);
    localparam int BW    = ELEMENT_WIDTH * ELEMENTS_PER_BLOCK;
    localparam int IDX_W = (ELEMENTS_PER_BLOCK > 1) ? $clog2(ELEMENTS_PER_BLOCK) : 1;

    localparam logic [LG_DEPTH:0]   MAX_COUNT = (LG_DEPTH+1)'(DEPTH);
    localparam logic [LG_DEPTH-1:0] LAST_ADDR = LG_DEPTH'(DEPTH - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(ELEMENTS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [LG_DEPTH-1:0] r_addr;
    logic [LG_DEPTH:0]   r_count;
    logic [IDX_W-1:0]    r_idx;
    logic [BW-1:0]       r_pack;
    logic [LG_DEPTH-1:0] r_sram_addr;
    logic [BW-1:0]       r_sram_din;

    logic [BW-1:0]       w_block;
    logic [LG_DEPTH:0]   w_count_sat;
    logic [LG_DEPTH-1:0] w_addr_next;

    // Partial block with the element currently on the bus merged into its slot.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_block = r_pack;
        w_block[r_idx*ELEMENT_WIDTH +: ELEMENT_WIDTH] = bus.io_elem_data;
    end

    assign w_count_sat = (bus.io_num_blocks > MAX_COUNT) ? MAX_COUNT : bus.io_num_blocks;
    assign w_addr_next = (r_addr == LAST_ADDR) ? '0 : r_addr + LG_DEPTH'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_pack      <= '0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.io_start) begin
                        r_addr  <= bus.io_base_addr;
                        r_count <= w_count_sat;
                        r_idx   <= '0;
                        r_state <= (w_count_sat == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.io_abort) begin
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else if (bus.io_elem_valid) begin
                        if (r_idx == LAST_IDX) begin
                            r_sram_din  <= w_block;
                            r_sram_addr <= r_addr;
                            r_idx       <= '0;
                            r_state     <= S_WRITE;
                        end else begin
                            r_pack <= w_block;
                            r_idx  <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.io_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_addr  <= w_addr_next;
                        r_count <= r_count - (LG_DEPTH+1)'(1);
                        r_state <= (r_count == (LG_DEPTH+1)'(1)) ? S_DONE : S_FILL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Abort must be able to kill the write in the very cycle it is raised.
    assign bus.io_sram_we    = (r_state == S_WRITE) && !bus.io_abort;
    assign bus.io_elem_ready = (r_state == S_FILL);
    assign bus.io_busy       = (r_state == S_FILL) || (r_state == S_WRITE);
    assign bus.io_done       = (r_state == S_DONE);
    assign bus.io_sram_addr  = r_sram_addr;
    assign bus.io_sram_din   = r_sram_din;
endmodule

// File: tb/tb_cache_sram_loader.sv
// Self-checking bench for cache_sram_loader: directed load scenarios with random data,
// compared against a block-level model of expected SRAM writes and completion timing.
module tb_cache_sram_loader;
    localparam int EW    = 32;
    localparam int EPB   = 4;
    localparam int DEPTH = 64;
    localparam int LGD   = 6;
    localparam int BW    = EW * EPB;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_sram_loader_if #(.ELEMENT_WIDTH(EW), .ELEMENTS_PER_BLOCK(EPB), .LG_DEPTH(LGD)) bus ();

    cache_sram_loader #(
        .ELEMENT_WIDTH(EW), .ELEMENTS_PER_BLOCK(EPB), .DEPTH(DEPTH), .LG_DEPTH(LGD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int             cyc;
        logic [LGD-1:0] addr;
        logic [BW-1:0]  din;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  done_q[$];
    int  busy_cnt;
    int  n_cmp = 0;
    int  n_err = 0;

    // Observed writes, done pulses and busy cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.io_sram_we) obs_q.push_back('{cyc, bus.io_sram_addr, bus.io_sram_din});
        if (bus.io_done) done_q.push_back(cyc);
        if (bus.io_busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
        busy_cnt = 0;
    endtask

    function automatic logic [BW-1:0] pack_block(input logic [EW-1:0] e[EPB]);
        logic [BW-1:0] b = '0;
        for (int k = 0; k < EPB; k++) b = b | (BW'(e[k]) << (k * EW));
        return b;
    endfunction

    task automatic start_load(input int base, input int n, output int sc);
        @(posedge clk); #1;
        bus.io_start      = 1'b1;
        bus.io_base_addr  = LGD'(base);
        bus.io_num_blocks = (LGD+1)'(n);
        sc = cyc;
        @(posedge clk); #1;
        bus.io_start = 1'b0;
    endtask

    // Presents one element (after optional random gaps) and returns once it is accepted.
    task automatic send_elem(input logic [EW-1:0] d, input int gap_pct, input bit noise);
        bit ok = 1'b0;
        for (int g = 0; g < 4; g++) begin
            if (gap_pct == 0 || $urandom_range(99) >= gap_pct) break;
            bus.io_elem_valid = 1'b0;
            if (noise) begin
                bus.io_start      = 1'($urandom);
                bus.io_base_addr  = LGD'($urandom);
                bus.io_num_blocks = (LGD+1)'($urandom);
            end
            @(posedge clk); #1;
        end
        bus.io_elem_valid = 1'b1;
        bus.io_elem_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.io_elem_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL accept_timeout: observed ready 0 expected 1");
        end
        @(posedge clk); #1;
        bus.io_elem_valid = 1'b0;
        bus.io_start      = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max);
        for (int t = 0; t < max; t++) begin
            @(negedge clk);
            if (bus.io_done) break;
        end
        wait_cycles(2);
    endtask

    // Full load: the model expects min(n, DEPTH) writes at (base+i) mod DEPTH.
    task automatic load(input int base, input int n, input int gap_pct, input bit noise,
                        input bit fixed);
        int            sc;
        int            nsat;
        logic [EW-1:0] e[EPB];
        clear_obs();
        nsat = (n > DEPTH) ? DEPTH : n;
        start_load(base, n, sc);
        for (int i = 0; i < nsat; i++) begin
            for (int k = 0; k < EPB; k++) e[k] = fixed ? EW'(32'h11 * (k + 1)) : EW'($urandom);
            exp_q.push_back('{0, LGD'((base + i) % DEPTH), pack_block(e)});
            for (int k = 0; k < EPB; k++) send_elem(e[k], gap_pct, noise);
        end
        wait_done(50);
    endtask

    task automatic check_writes(input string tag, input bit timing);
        int ncmp;
        check({tag, "_nwr"}, BW'(obs_q.size()), BW'(exp_q.size()));
        ncmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++) begin
            check({tag, "_addr"}, BW'(obs_q[i].addr), BW'(exp_q[i].addr));
            check({tag, "_din"}, obs_q[i].din, exp_q[i].din);
            if (timing && i > 0) check({tag, "_gap"}, BW'(obs_q[i].cyc - obs_q[i-1].cyc), BW'(EPB + 1));
        end
        check({tag, "_ndone"}, BW'(done_q.size()), BW'(1));
        if (done_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_done_cyc"}, BW'(done_q[0]), BW'(obs_q[obs_q.size()-1].cyc + 1));
    endtask

    initial begin
        int sc;
        logic [EW-1:0] d;

        bus.io_start      = 1'b0;
        bus.io_base_addr  = '0;
        bus.io_num_blocks = '0;
        bus.io_abort      = 1'b0;
        bus.io_elem_valid = 1'b0;
        bus.io_elem_data  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_we",    BW'(bus.io_sram_we),    BW'(0));
        check("rst_ready", BW'(bus.io_elem_ready), BW'(0));
        check("rst_busy",  BW'(bus.io_busy),       BW'(0));
        check("rst_done",  BW'(bus.io_done),       BW'(0));
        check("rst_addr",  BW'(bus.io_sram_addr),  BW'(0));
        check("rst_din",   bus.io_sram_din,        BW'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_cycles(2);

        // Single block with the fixed 0x11..0x44 pattern.
        load(0, 1, 0, 1'b0, 1'b1);
        check_writes("single", 1'b1);
        check("single_din_const", exp_q[0].din, 128'h00000044_00000033_00000022_00000011);

        // Address wrap from 62 through 0.
        load(62, 3, 0, 1'b0, 1'b0);
        check_writes("wrap", 1'b1);

        // Zero-count load.
        clear_obs();
        start_load(9, 0, sc);
        wait_cycles(4);
        check("zero_nwr",      BW'(obs_q.size()),  BW'(0));
        check("zero_busy",     BW'(busy_cnt),      BW'(0));
        check("zero_ndone",    BW'(done_q.size()), BW'(1));
        if (done_q.size() > 0) check("zero_done_cyc", BW'(done_q[0]), BW'(sc + 1));

        // Abort after two accepted elements, then a clean reload.
        clear_obs();
        start_load(5, 1, sc);
        send_elem(EW'($urandom), 0, 1'b0);
        send_elem(EW'($urandom), 0, 1'b0);
        bus.io_abort = 1'b1;
        @(negedge clk);
        check("abort_fill_we", BW'(bus.io_sram_we), BW'(0));
        @(posedge clk); #1;
        bus.io_abort = 1'b0;
        @(negedge clk);
        check("abort_fill_busy", BW'(bus.io_busy), BW'(0));
        wait_cycles(8);
        check("abort_fill_nwr",   BW'(obs_q.size()),  BW'(0));
        check("abort_fill_ndone", BW'(done_q.size()), BW'(0));
        load(7, 1, 0, 1'b0, 1'b0);
        check_writes("reload", 1'b1);

        // Abort coinciding with acceptance of the final element.
        clear_obs();
        start_load(11, 1, sc);
        for (int k = 0; k < EPB - 1; k++) send_elem(EW'($urandom), 0, 1'b0);
        bus.io_elem_valid = 1'b1;
        bus.io_elem_data  = EW'($urandom);
        bus.io_abort      = 1'b1;
        @(negedge clk);
        check("abort_last_ready", BW'(bus.io_elem_ready), BW'(1));
        @(posedge clk); #1;
        bus.io_elem_valid = 1'b0;
        bus.io_abort      = 1'b0;
        wait_cycles(8);
        check("abort_last_nwr",   BW'(obs_q.size()),  BW'(0));
        check("abort_last_ndone", BW'(done_q.size()), BW'(0));
        check("abort_last_busy",  BW'(bus.io_busy),   BW'(0));

        // Abort during the write cycle.
        clear_obs();
        start_load(20, 2, sc);
        for (int k = 0; k < EPB; k++) send_elem(EW'($urandom), 0, 1'b0);
        bus.io_abort = 1'b1;
        @(negedge clk);
        check("abort_wr_we",   BW'(bus.io_sram_we), BW'(0));
        check("abort_wr_busy", BW'(bus.io_busy),    BW'(1));
        @(posedge clk); #1;
        bus.io_abort = 1'b0;
        wait_cycles(8);
        check("abort_wr_nwr",   BW'(obs_q.size()),  BW'(0));
        check("abort_wr_ndone", BW'(done_q.size()), BW'(0));

        // Random valid gaps with start pulses while busy.
        for (int r = 0; r < 3; r++) begin
            load($urandom_range(DEPTH - 1), 2 + $urandom_range(2), 40, 1'b1, 1'b0);
            check_writes("stall", 1'b0);
        end
        load(0, 1, 50, 1'b1, 1'b1);
        check_writes("stall_fixed", 1'b0);

        // Count above DEPTH saturates.
        load(3, 70, 0, 1'b0, 1'b0);
        check_writes("sat", 1'b1);

        // Reset asserted in the write cycle.
        clear_obs();
        start_load(30, 2, sc);
        for (int k = 0; k < EPB; k++) send_elem(EW'($urandom), 0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rstwr_we",   BW'(bus.io_sram_we),   BW'(0));
        check("rstwr_busy", BW'(bus.io_busy),      BW'(0));
        check("rstwr_addr", BW'(bus.io_sram_addr), BW'(0));
        check("rstwr_din",  bus.io_sram_din,       BW'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_cycles(12);
        check("rstwr_nwr",   BW'(obs_q.size()),     BW'(0));
        check("rstwr_ndone", BW'(done_q.size()),    BW'(0));
        check("rstwr_ready", BW'(bus.io_elem_ready), BW'(0));
        check("rstwr_din2",  bus.io_sram_din,       BW'(0));

        d = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
